// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan readback path: segment constants,
// digit-select indices, FSM states and the BCD-to-binary helper.
package seg7_scan_capture_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int AN_TENS = 1;
  localparam int AN_ONES = 0;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_PUBLISH = 1'b1
  } state_e;

  // tens*10 + ones as (tens<<3) + (tens<<1) + ones
  function automatic logic [7:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] t;
    t = {4'b0000, tens};
    return (t << 3) + (t << 1) + {4'b0000, ones};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; a blank tens digit reads as 0 so
// leading-zero blanking on the display side round-trips cleanly.
module seg7_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       is_tens,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    bcd     = 4'd0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: invalid = ~is_tens;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed two-digit 7-segment scan bus, debounces digit dwells,
// decodes them and republishes the displayed value 0-99 with a staleness flag.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] an_in,
  output logic [7:0] value_out,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       valid,
  output logic       frame_stb,
  output logic       err_pattern,
  output logic       err_an
);

  localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LOAD     = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]      DWELL_ACCEPT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]      DWELL_MAX    = 8'(STABLE_CYCLES);
  // Raw input flops reset to the "nothing lit, nothing selected" level
  localparam logic [6:0]      SEG_IDLE     = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [1:0]      AN_IDLE      = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [6:0]    seg_raw_q, seg_raw_d;
  logic [1:0]    an_raw_q, an_raw_d;
  logic [6:0]    prev_seg_q, prev_seg_d;
  logic [1:0]    prev_an_q, prev_an_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [3:0]    tens_hold_q, tens_hold_d;
  logic [3:0]    ones_hold_q, ones_hold_d;
  logic          tens_flag_q, tens_flag_d;
  logic          ones_flag_q, ones_flag_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_e        state_q, state_d;
  logic [7:0]    value_q, value_d;
  logic [3:0]    tens_out_q, tens_out_d;
  logic [3:0]    ones_out_q, ones_out_d;
  logic          valid_q, valid_d;
  logic          frame_stb_q, frame_stb_d;
  logic          err_pattern_q, err_pattern_d;
  logic          err_an_q, err_an_d;

  logic [6:0]    seg_n;
  logic [1:0]    an_n;
  logic          same, one_sel, both_sel, prev_both, accept;
  logic          dec_is_tens, dec_invalid;
  logic [3:0]    dec_bcd;

  assign seg_raw_d = seg_in;
  assign an_raw_d  = an_in;
  assign seg_n     = SEG_ACTIVE_LOW ? ~seg_raw_q : seg_raw_q;
  assign an_n      = AN_ACTIVE_LOW ? ~an_raw_q : an_raw_q;
  assign prev_seg_d = seg_n;
  assign prev_an_d  = an_n;

  assign same      = ({seg_n, an_n} == {prev_seg_q, prev_an_q});
  assign one_sel   = an_n[AN_TENS] ^ an_n[AN_ONES];
  assign both_sel  = an_n[AN_TENS] & an_n[AN_ONES];
  assign prev_both = prev_an_q[AN_TENS] & prev_an_q[AN_ONES];
  // The counter saturates one past the accept point so a long dwell fires once
  assign accept    = (dwell_q == DWELL_ACCEPT);
  assign err_an_d  = both_sel & ~prev_both;

  always_comb begin
    dwell_d = 8'd0;
    if (same && one_sel) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 8'd1;
    end
  end

  // dwell_q counts comparisons up to last cycle, so the stable pattern is in prev_*
  assign dec_is_tens = prev_an_q[AN_TENS];

  seg7_decode u_decode (
    .pattern (prev_seg_q),
    .is_tens (dec_is_tens),
    .bcd     (dec_bcd),
    .invalid (dec_invalid)
  );

  always_comb begin
    state_d       = state_q;
    tens_hold_d   = tens_hold_q;
    ones_hold_d   = ones_hold_q;
    tens_flag_d   = tens_flag_q;
    ones_flag_d   = ones_flag_q;
    tmo_d         = tmo_q;
    value_d       = value_q;
    tens_out_d    = tens_out_q;
    ones_out_d    = ones_out_q;
    valid_d       = valid_q;
    frame_stb_d   = 1'b0;
    err_pattern_d = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
        if (tmo_d == '0) valid_d = 1'b0;
      end
      S_PUBLISH: begin
        value_d     = bcd2_to_bin(tens_hold_q, ones_hold_q);
        tens_out_d  = tens_hold_q;
        ones_out_d  = ones_hold_q;
        frame_stb_d = 1'b1;
        valid_d     = 1'b1;
        tens_flag_d = 1'b0;
        ones_flag_d = 1'b0;
        tmo_d       = TMO_LOAD;
        state_d     = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase

    // Applied after the flag clear so a same-cycle acceptance starts the next frame
    if (accept) begin
      if (dec_invalid) begin
        err_pattern_d = 1'b1;
        if (dec_is_tens) tens_flag_d = 1'b0;
        else             ones_flag_d = 1'b0;
      end else if (dec_is_tens) begin
        tens_hold_d = dec_bcd;
        tens_flag_d = 1'b1;
      end else begin
        ones_hold_d = dec_bcd;
        ones_flag_d = 1'b1;
      end
    end

    if (state_q == S_COLLECT && tens_flag_d && ones_flag_d) state_d = S_PUBLISH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_raw_q     <= SEG_IDLE;
      an_raw_q      <= AN_IDLE;
      prev_seg_q    <= 7'd0;
      prev_an_q     <= 2'd0;
      dwell_q       <= 8'd0;
      tens_hold_q   <= 4'd0;
      ones_hold_q   <= 4'd0;
      tens_flag_q   <= 1'b0;
      ones_flag_q   <= 1'b0;
      tmo_q         <= '0;
      state_q       <= S_COLLECT;
      value_q       <= 8'd0;
      tens_out_q    <= 4'd0;
      ones_out_q    <= 4'd0;
      valid_q       <= 1'b0;
      frame_stb_q   <= 1'b0;
      err_pattern_q <= 1'b0;
      err_an_q      <= 1'b0;
    end else begin
      seg_raw_q     <= seg_raw_d;
      an_raw_q      <= an_raw_d;
      prev_seg_q    <= prev_seg_d;
      prev_an_q     <= prev_an_d;
      dwell_q       <= dwell_d;
      tens_hold_q   <= tens_hold_d;
      ones_hold_q   <= ones_hold_d;
      tens_flag_q   <= tens_flag_d;
      ones_flag_q   <= ones_flag_d;
      tmo_q         <= tmo_d;
      state_q       <= state_d;
      value_q       <= value_d;
      tens_out_q    <= tens_out_d;
      ones_out_q    <= ones_out_d;
      valid_q       <= valid_d;
      frame_stb_q   <= frame_stb_d;
      err_pattern_q <= err_pattern_d;
      err_an_q      <= err_an_d;
    end
  end

  assign value_out   = value_q;
  assign tens_out    = tens_out_q;
  assign ones_out    = ones_out_q;
  assign valid       = valid_q;
  assign frame_stb   = frame_stb_q;
  assign err_pattern = err_pattern_q;
  assign err_an      = err_an_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: drives active-low scan patterns and
// checks reconstructed values, error pulses and timeout behaviour.
module tb_seg7_scan_capture;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [1:0] AN_T = 2'b01;
  localparam logic [1:0] AN_O = 2'b10;
  localparam logic [1:0] AN_NONE = 2'b11;
  localparam logic [1:0] AN_BOTH = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = BL;
  logic [1:0] an_in = AN_NONE;
  logic [7:0] value_out;
  logic [3:0] tens_out, ones_out;
  logic       valid, frame_stb, err_pattern, err_an;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int stb_cyc = 0;
  int fall_cyc = 0;
  int errp_cnt = 0;
  int erran_cnt = 0;
  logic valid_prev = 1'b0;

  seg7_scan_capture #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (200),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value_out   (value_out),
    .tens_out    (tens_out),
    .ones_out    (ones_out),
    .valid       (valid),
    .frame_stb   (frame_stb),
    .err_pattern (err_pattern),
    .err_an      (err_an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    valid_prev <= valid;
    if (frame_stb) begin
      stb_cnt <= stb_cnt + 1;
      stb_cyc <= cyc;
    end
    if (valid_prev && !valid) fall_cyc <= cyc;
    if (err_pattern) errp_cnt <= errp_cnt + 1;
    if (err_an) erran_cnt <= erran_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%0d expected=%0d ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [1:0] a, input int n);
    @(negedge clk);
    seg_in = s;
    an_in  = a;
    for (int i = 0; i < n; i++) @(negedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_value", value_out, 0);
    check("rst_tens", tens_out, 0);
    check("rst_ones", ones_out, 0);
    check("rst_valid", valid, 0);
    check("rst_stb", frame_stb, 0);
    check("rst_errp", err_pattern, 0);
    check("rst_erran", err_an, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic scan of 47
    drive(D4, AN_T, 40);
    drive(D7, AN_O, 40);
    check("t1_stb_cnt", stb_cnt, 1);
    check("t1_value", value_out, 47);
    check("t1_tens", tens_out, 4);
    check("t1_ones", ones_out, 7);
    check("t1_valid", valid, 1);

    // 2: glitching tens digit never settles, then settles at 9
    drive(D1, AN_O, 20);
    for (int k = 0; k < 8; k++) begin
      drive(D9, AN_T, 5);
      drive(D3, AN_T, 5);
    end
    check("t2_no_stb", stb_cnt, 1);
    drive(D9, AN_T, 20);
    check("t2_stb_cnt", stb_cnt, 2);
    check("t2_value", value_out, 91);
    check("t2_valid", valid, 1);

    // 3: blank tens is zero, blank ones is an error
    drive(BL, AN_T, 20);
    drive(BL, AN_O, 20);
    check("t3_errp", errp_cnt, 1);
    check("t3_no_stb", stb_cnt, 2);
    drive(D0, AN_O, 20);
    check("t3_stb_cnt", stb_cnt, 3);
    check("t3_value", value_out, 0);
    check("t3_errp_same", errp_cnt, 1);

    // 4: both digits selected
    drive(D5, AN_BOTH, 30);
    check("t4_erran", erran_cnt, 1);
    check("t4_no_stb", stb_cnt, 3);
    drive(D9, AN_T, 20);
    drive(D9, AN_O, 20);
    check("t4_stb_cnt", stb_cnt, 4);
    check("t4_value", value_out, 99);
    check("t4_erran_same", erran_cnt, 1);

    // 5: timeout after publishing 58
    drive(D5, AN_T, 20);
    drive(D8, AN_O, 20);
    check("t5_stb_cnt", stb_cnt, 5);
    check("t5_value", value_out, 58);
    check("t5_valid_hi", valid, 1);
    drive(BL, AN_NONE, 250);
    check("t5_valid_lo", valid, 0);
    check("t5_fall_delay", fall_cyc - stb_cyc, 200);
    check("t5_value_hold", value_out, 58);

    // 6: reset with tens captured, ones pending
    drive(D3, AN_T, 20);
    @(negedge clk);
    rst_n = 1'b0;
    seg_in = D4;
    an_in  = AN_O;
    repeat (2) @(negedge clk);
    #2;
    check("t6_value", value_out, 0);
    check("t6_tens", tens_out, 0);
    check("t6_ones", ones_out, 0);
    check("t6_valid", valid, 0);
    check("t6_stb", frame_stb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(D4, AN_O, 30);
    check("t6_no_stb", stb_cnt, 5);
    check("t6_value_zero", value_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
